// File: rtl/cache_line_filler.sv
// Line-fill responder: fetches an 8-word line critical-word-first from a pipelined
// read port, buffers it, then replays it to the cache as a contiguous 8-cycle burst.
module cache_line_filler #(
    parameter int ADDR_BITS       = 26,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sdram_req,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 sdram_fill,
    output logic [15:0]          data_from_sdram,
    output logic                 busy,
    output logic                 mem_rd,
    output logic [ADDR_BITS-2:0] mem_addr,
    input  logic                 mem_ready,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_rvalid
);

    localparam int LINE_BITS = ADDR_BITS - 4;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t               state, state_nx;
    logic [LINE_BITS-1:0] line, line_nx;
    logic [2:0]           crit, crit_nx;
    logic [3:0]           iss, iss_nx;
    logic [3:0]           ret, ret_nx;
    logic [3:0]           in_flight;
    logic [2:0]           k, k_nx;
    logic                 abort, abort_nx;
    logic                 accept;
    logic                 mem_rd_nx;
    logic [ADDR_BITS-2:0] mem_addr_nx;
    logic                 sdram_fill_nx;
    logic [15:0]          data_nx;
    logic                 buf_we;
    logic [2:0]           buf_wa;
    logic [15:0]          line_buf [8];
    logic                 unused_addr_bit;

    // Byte-lane bit of the request address carries no information for 16-bit words.
    assign unused_addr_bit = req_addr[0];

    assign busy   = (state != IDLE);
    assign accept = mem_rd & mem_ready;
    assign buf_wa = ret[2:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            line            <= '0;
            crit            <= '0;
            iss             <= '0;
            ret             <= '0;
            k               <= '0;
            abort           <= 1'b0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            sdram_fill      <= 1'b0;
            data_from_sdram <= '0;
        end else begin
            state           <= state_nx;
            line            <= line_nx;
            crit            <= crit_nx;
            iss             <= iss_nx;
            ret             <= ret_nx;
            k               <= k_nx;
            abort           <= abort_nx;
            mem_rd          <= mem_rd_nx;
            mem_addr        <= mem_addr_nx;
            sdram_fill      <= sdram_fill_nx;
            data_from_sdram <= data_nx;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf[buf_wa] <= mem_rdata;
    end

    always_comb begin
        state_nx      = state;
        line_nx       = line;
        crit_nx       = crit;
        iss_nx        = iss;
        ret_nx        = ret;
        k_nx          = k;
        abort_nx      = abort;
        mem_rd_nx     = 1'b0;
        mem_addr_nx   = mem_addr;
        sdram_fill_nx = 1'b0;
        data_nx       = data_from_sdram;
        buf_we        = 1'b0;
        in_flight     = iss - ret;

        case (state)
            IDLE: begin
                abort_nx = 1'b0;
                if (sdram_req) begin
                    line_nx     = req_addr[ADDR_BITS-1:4];
                    crit_nx     = req_addr[3:1];
                    iss_nx      = '0;
                    ret_nx      = '0;
                    mem_rd_nx   = 1'b1;
                    mem_addr_nx = req_addr[ADDR_BITS-1:1];
                    state_nx    = FETCH;
                end
            end

            FETCH: begin
                if (!sdram_req) abort_nx = 1'b1;
                iss_nx = iss + {3'b000, accept};
                if (mem_rvalid && !ret[3]) begin
                    buf_we = 1'b1;
                    ret_nx = ret + 4'd1;
                end
                // Outstanding is evaluated after this cycle's accept and return.
                in_flight   = iss_nx - ret_nx;
                mem_rd_nx   = !iss_nx[3] && (in_flight < 4'(MAX_OUTSTANDING));
                mem_addr_nx = {line, 3'(crit + iss_nx[2:0])};
                if (ret[3]) begin
                    mem_rd_nx = 1'b0;
                    if (abort_nx) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx      = STREAM;
                        k_nx          = '0;
                        sdram_fill_nx = 1'b1;
                        data_nx       = line_buf[0];
                    end
                end
            end

            STREAM: begin
                if (k == 3'd7) begin
                    state_nx = IDLE;
                end else begin
                    k_nx    = k + 3'd1;
                    data_nx = line_buf[k + 3'd1];
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_filler.sv
// Bench for cache_line_filler: table of fill scenarios driven against a randomized
// in-order memory model; expected addresses and stream data come from line/crit arithmetic.
module tb_cache_line_filler;

    localparam int AB   = 26;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          reset_n, sdram_req, mem_ready, mem_rvalid;
    logic [AB-1:0] req_addr;
    logic [15:0]   mem_rdata, data_from_sdram;
    logic          sdram_fill, busy, mem_rd;
    logic [AB-2:0] mem_addr;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cache_line_filler #(.ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n), .sdram_req(sdram_req), .req_addr(req_addr),
        .sdram_fill(sdram_fill), .data_from_sdram(data_from_sdram), .busy(busy),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    typedef struct {
        logic [AB-1:0] addr;
        int            mode;        // 0: ready always, 1: ready 1,0,0 repeating, 2: random
        int            lat_lo, lat_hi;
        int            drop_after;  // withdraw request after this many accepts (0 = never)
        int            rst_after;   // reset after this many accepts (0 = never)
        bit            spur;        // spurious mem_rvalid in the latch cycle
        bit            b2b;         // request in the first IDLE cycle after previous stream
        logic [15:0]   salt;
        logic [AB-2:0] exp_first;
        bit            exp_fill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [AB-1:0] a, input int mode, input int lo, input int hi,
                                input int drop, input int rst, input bit spur, input bit b2b,
                                input logic [15:0] salt, input logic [AB-2:0] first, input bit fill);
        vec_t v;
        v.addr = a; v.mode = mode; v.lat_lo = lo; v.lat_hi = hi; v.drop_after = drop;
        v.rst_after = rst; v.spur = spur; v.b2b = b2b; v.salt = salt;
        v.exp_first = first; v.exp_fill = fill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fill"}, sdram_fill, 0);
        chk({tag, "_data"}, data_from_sdram, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sdram_req  = 1'b0;
            mem_ready  = 1'($urandom_range(1, 0));
            mem_rvalid = 1'($urandom_range(1, 0));
            mem_rdata  = 16'($urandom);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_mem_rd", mem_rd, 0);
        end
        mem_rvalid = 1'b0;
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run_fill(input vec_t v);
        int t, acc, rets, last, due, last_due, lat, k, tend, line, crit;
        bit req_on, rst_now;
        int          due_q[$];
        logic [15:0] dat_q[$];
        logic [15:0] e;
        line = int'(v.addr >> 4);
        crit = int'((v.addr >> 1) & 7);
        acc = 0; rets = 0; last = -1; last_due = 0; req_on = 1; rst_now = 0;
        sdram_req  = 1'b1;
        req_addr   = v.addr;
        mem_ready  = 1'b0;
        mem_rvalid = v.spur;
        mem_rdata  = 16'($urandom);
        chk("latch_idle", busy, 0);
        @(negedge clk);
        req_addr = AB'($urandom);
        chk("latch_busy", busy, 1);
        chk("latch_mem_rd", mem_rd, 1);
        for (t = 1; t < 400; t++) begin
            if (rst_now) begin
                reset_n = 1'b0; sdram_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                chk_reset_state("midrst");
                return;
            end
            case (v.mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (t % 3) == 1;
                default: mem_ready = 1'($urandom_range(1, 0));
            endcase
            sdram_req  = req_on;
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (due_q.size() > 0 && due_q[0] <= t) begin
                void'(due_q.pop_front());
                mem_rvalid = 1'b1;
                mem_rdata  = dat_q.pop_front();
                rets++;
                if (rets == 8) last = t;
            end
            if (acc == 8) chk("rd_after_8", mem_rd, 0);
            if (mem_rd && mem_ready) begin
                chk("mem_addr", mem_addr, 32'(line * 8 + (crit + acc) % 8));
                if (acc == 0) chk("first_addr", mem_addr, v.exp_first);
                acc++;
                lat      = int'($urandom_range(v.lat_hi, v.lat_lo));
                due      = (t + lat > last_due) ? t + lat : last_due + 1;
                last_due = due;
                due_q.push_back(due);
                dat_q.push_back(mem_addr[15:0] ^ v.salt);
                if (acc == v.drop_after) req_on = 0;
                if (acc == v.rst_after) rst_now = 1;
            end
            chk("outstanding_le_max", (acc - rets) <= MAXO, 1);
            tend = (last < 0) ? -1 : last + (v.exp_fill ? 10 : 2);
            chk("fill", sdram_fill, (v.exp_fill && last >= 0 && t == last + 2));
            if (v.exp_fill && last >= 0 && t >= last + 2) begin
                k = (t - last - 2 > 7) ? 7 : t - last - 2;
                e = 16'(line * 8 + (crit + k) % 8) ^ v.salt;
                chk("stream_data", data_from_sdram, e);
                if (k == 0) req_on = 0;
            end
            chk("busy", busy, (t != tend));
            if (t == tend) begin
                chk("accepts_total", acc, 8);
                return;
            end
            @(negedge clk);
        end
        n_vec++; n_miss++;
        $display("FAIL timeout: fill did not complete, accepts %0d returns %0d", acc, rets);
        reset_n = 1'b0; sdram_req = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [AB-1:0] ra;
        int drop;
        reset_n = 1'b0; sdram_req = 1'b0; req_addr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        vecs.push_back(mk(26'h0001234, 0, 2, 2, 0, 0, 0, 0, 16'h0000, 25'h091A, 1));
        vecs.push_back(mk(26'h000001E, 0, 2, 2, 0, 0, 0, 0, 16'h0000, 25'h000F, 1));
        vecs.push_back(mk(26'h0ABCDEC, 1, 1, 6, 0, 0, 0, 0, 16'h5A3C, 25'h55E6F6, 1));
        vecs.push_back(mk(26'h0000450, 0, 1, 3, 3, 0, 0, 0, 16'h1111, 25'h0228, 0));
        vecs.push_back(mk(26'h3FFFFF2, 2, 1, 6, 0, 0, 0, 0, 16'hBEEF, 25'h1FFFFF9, 1));
        vecs.push_back(mk(26'h0000C0A, 2, 1, 4, 0, 0, 1, 1, 16'h0F0F, 25'h0605, 1));
        vecs.push_back(mk(26'h0123456, 0, 2, 2, 0, 5, 0, 0, 16'h0000, 25'h091A2B, 1));
        vecs.push_back(mk(26'h0123456, 0, 2, 2, 0, 0, 0, 0, 16'h7777, 25'h091A2B, 1));
        for (int i = 0; i < 12; i++) begin
            ra   = AB'($urandom);
            drop = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 1)) : 0;
            vecs.push_back(mk(ra, 2, 1, 6, drop, 0, 1'($urandom_range(1, 0)),
                              1'($urandom_range(1, 0)), 16'($urandom), ra[AB-1:1], drop == 0));
        end

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset_n = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            if (!vecs[i].b2b) idle(2);
            run_fill(vecs[i]);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
